// File: rtl/priority_decoder_seq.sv
// Timed one-hot strobe generator: decodes a CODE_W-bit index into a 2**CODE_W one-hot y.
// Latency: y is registered on the accepting edge and held HOLD cycles, then GAP idle cycles.
// Backpressure: in_ready is low outside IDLE, so one code is accepted per HOLD+GAP+1 cycles.
//
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready  - code handshake; transfer when both are high on a rising edge
//   code                - index to decode
//   y, y_valid          - registered one-hot strobe and its qualifier (high while y != 0)
//   busy                - high whenever the block is not in IDLE
//   count               - 16-bit saturating accepted-code counter (only with PD_COUNT_EN)
//
// Optional feature: define PD_COUNT_EN to add the count port and its counter.

module priority_decoder_seq #(
    parameter int CODE_W = 3,
    parameter int HOLD   = 4,
    parameter int GAP    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CODE_W-1:0]      code,
    output logic [(1<<CODE_W)-1:0] y,
    output logic                   y_valid,
`ifdef PD_COUNT_EN
    output logic                   busy,
    output logic [15:0]            count
`else
    output logic                   busy
`endif
);

    localparam int OUT_W = 1 << CODE_W;

    // Counter reload values; the GAP load is only used when GAP > 0, so the
    // guard keeps the GAP == 0 build from computing a negative constant.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
    localparam logic [7:0] GAP_LOAD  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
    localparam bit         HAS_GAP   = (GAP > 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] cnt;

    // Handshake and status are pure decodes of the registered state, so in_ready
    // never has a combinational path from in_valid.
    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    wire transfer = in_valid && (state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 8'd0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (transfer) begin
                        y       <= {{(OUT_W-1){1'b0}}, 1'b1} << code;
                        y_valid <= 1'b1;
                        cnt     <= HOLD_LOAD;
                        state   <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    // code/in_valid are deliberately ignored here; y stays frozen.
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        y       <= '0;
                        y_valid <= 1'b0;
                        if (HAS_GAP) begin
                            cnt   <= GAP_LOAD;
                            state <= S_GAP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cnt     <= 8'd0;
                    y       <= '0;
                    y_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PD_COUNT_EN
    logic [15:0] count_q;

    // Saturating count of accepted codes; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'd0;
        end else if (transfer && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign count = count_q;
`endif

endmodule

// File: tb/tb_priority_decoder_seq.sv
// Directed bench for priority_decoder_seq: instance a uses HOLD=4/GAP=1,
// instance b uses HOLD=1/GAP=0. Inputs change 1 time unit after a rising
// edge and outputs are sampled at that same point.

module tb_priority_decoder_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic       a_valid = 1'b0;
    logic       a_ready;
    logic [2:0] a_code = 3'd0;
    logic [7:0] a_y;
    logic       a_y_valid;
    logic       a_busy;

    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [2:0] b_code = 3'd0;
    logic [7:0] b_y;
    logic       b_y_valid;
    logic       b_busy;

`ifdef PD_COUNT_EN
    logic [15:0] a_count;
    logic [15:0] b_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    priority_decoder_seq #(.CODE_W(3), .HOLD(4), .GAP(1)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (a_valid),
        .in_ready (a_ready),
        .code     (a_code),
        .y        (a_y),
        .y_valid  (a_y_valid),
`ifdef PD_COUNT_EN
        .busy     (a_busy),
        .count    (a_count)
`else
        .busy     (a_busy)
`endif
    );

    priority_decoder_seq #(.CODE_W(3), .HOLD(1), .GAP(0)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (b_valid),
        .in_ready (b_ready),
        .code     (b_code),
        .y        (b_y),
        .y_valid  (b_y_valid),
`ifdef PD_COUNT_EN
        .busy     (b_busy),
        .count    (b_count)
`else
        .busy     (b_busy)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_checks++; if (a_y !== 8'h00) begin n_fail++; $display("FAIL reset_y: got %h expected 00", a_y); end
        n_checks++; if (a_y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_y_valid: got %b expected 0", a_y_valid); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", a_ready); end
`ifdef PD_COUNT_EN
        n_checks++; if (a_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %h expected 0000", a_count); end
`endif
    endtask

    // Transfer code 5 at edge k and follow it through k+5.
    task automatic test_single();
        a_valid = 1'b1;
        a_code  = 3'd5;
        step();                                   // edge k
        a_valid = 1'b0;
        a_code  = 3'd0;
        exp_count++;
        for (int i = 0; i < 4; i++) begin         // edges k..k+3
            n_checks++; if (a_y !== 8'b0010_0000) begin n_fail++; $display("FAIL single_y_hold%0d: got %h expected 20", i, a_y); end
            n_checks++; if (a_y_valid !== 1'b1) begin n_fail++; $display("FAIL single_y_valid%0d: got %b expected 1", i, a_y_valid); end
            n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready%0d: got %b expected 0", i, a_ready); end
            step();
        end
        // edge k+4: strobe ends, GAP cycle
        n_checks++; if (a_y !== 8'h00) begin n_fail++; $display("FAIL single_y_end: got %h expected 00", a_y); end
        n_checks++; if (a_y_valid !== 1'b0) begin n_fail++; $display("FAIL single_y_valid_end: got %b expected 0", a_y_valid); end
        n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_gap: got %b expected 0", a_ready); end
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_gap: got %b expected 1", a_busy); end
        step();                                   // edge k+5: back in IDLE
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_idle: got %b expected 1", a_ready); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b expected 0", a_busy); end
    endtask

    // Codes 0..7 with in_valid held high; transfers must be 6 cycles apart.
    task automatic test_sweep();
        logic [7:0] exp_y [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        int idx   = 0;
        int cyc   = 0;
        int last  = 0;
        logic rdy;
        a_valid = 1'b1;
        a_code  = 3'd0;
        while (idx < 8 && cyc < 100) begin
            rdy = a_ready;
            step();
            cyc++;
            if (rdy) begin
                exp_count++;
                n_checks++; if (a_y !== exp_y[idx]) begin n_fail++; $display("FAIL sweep_y%0d: got %h expected %h", idx, a_y, exp_y[idx]); end
                if (idx > 0) begin
                    n_checks++; if (cyc - last !== 6) begin n_fail++; $display("FAIL sweep_period%0d: got %0d expected 6", idx, cyc - last); end
                end
                last = cyc;
                idx++;
                a_code = 3'(idx);
            end
        end
        a_valid = 1'b0;
        n_checks++; if (idx !== 8) begin n_fail++; $display("FAIL sweep_timeout: got %0d transfers expected 8", idx); end
        // Let the last strobe drain to IDLE.
        for (int i = 0; i < 20 && !a_ready; i++) step();
    endtask

    task automatic test_ignore_busy();
        a_valid = 1'b1;
        a_code  = 3'd2;
        step();                                   // edge k
        exp_count++;
        n_checks++; if (a_y !== 8'h04) begin n_fail++; $display("FAIL busy_y_first: got %h expected 04", a_y); end
        for (int i = 0; i < 3; i++) begin         // edges k+1..k+3
            a_code  = 3'(i * 3 + 1);
            a_valid = (i % 2 == 0);
            step();
            n_checks++; if (a_y !== 8'h04) begin n_fail++; $display("FAIL busy_y_hold%0d: got %h expected 04", i, a_y); end
        end
        a_valid = 1'b1;
        a_code  = 3'd7;
        step();                                   // edge k+4
        n_checks++; if (a_y !== 8'h00) begin n_fail++; $display("FAIL busy_y_end: got %h expected 00", a_y); end
        a_valid = 1'b0;
        step();                                   // edge k+5
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL busy_ready_idle: got %b expected 1", a_ready); end
`ifdef PD_COUNT_EN
        n_checks++; if (a_count !== 16'(exp_count)) begin n_fail++; $display("FAIL busy_count: got %0d expected %0d", a_count, exp_count); end
`endif
    endtask

    task automatic test_reset_mid();
        a_valid = 1'b1;
        a_code  = 3'd6;
        step();                                   // edge k
        a_valid = 1'b0;
        step();
        step();                                   // two cycles into DRIVE
        n_checks++; if (a_y !== 8'h40) begin n_fail++; $display("FAIL midrst_y_before: got %h expected 40", a_y); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (a_y !== 8'h00) begin n_fail++; $display("FAIL midrst_y_async: got %h expected 00", a_y); end
        n_checks++; if (a_y_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_y_valid: got %b expected 0", a_y_valid); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", a_busy); end
        #1 rst_n = 1'b1;
        exp_count = 0;
        a_valid = 1'b1;
        a_code  = 3'd3;
        step();                                   // first edge after release
        a_valid = 1'b0;
        exp_count++;
        n_checks++; if (a_y !== 8'h08) begin n_fail++; $display("FAIL midrst_y_after: got %h expected 08", a_y); end
`ifdef PD_COUNT_EN
        n_checks++; if (a_count !== 16'd1) begin n_fail++; $display("FAIL midrst_count: got %0d expected 1", a_count); end
`endif
        for (int i = 0; i < 20 && !a_ready; i++) step();
    endtask

    task automatic test_boundary();
        logic [7:0] exp_y [6] = '{8'h02, 8'h00, 8'h02, 8'h00, 8'h02, 8'h00};
        b_valid = 1'b1;
        b_code  = 3'd1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++; if (b_y !== exp_y[i]) begin n_fail++; $display("FAIL bound_y%0d: got %h expected %h", i, b_y, exp_y[i]); end
            n_checks++; if (b_y_valid !== (exp_y[i] != 8'h00)) begin n_fail++; $display("FAIL bound_y_valid%0d: got %b", i, b_y_valid); end
        end
        b_valid = 1'b0;
`ifdef PD_COUNT_EN
        n_checks++; if (b_count !== 16'd3) begin n_fail++; $display("FAIL bound_count: got %0d expected 3", b_count); end
        dut_b.count_q = 16'hFFFE;
        b_valid = 1'b1;
        step();                                   // transfer -> FFFF
        step();
        step();                                   // transfer, saturated
        b_valid = 1'b0;
        step();
        n_checks++; if (b_count !== 16'hFFFF) begin n_fail++; $display("FAIL bound_count_sat: got %h expected ffff", b_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_ignore_busy();
        test_reset_mid();
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case something above never returns.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/priority_decoder_seq.md
# priority_decoder_seq

Sequential 3-to-8 one-hot decoder that regenerates a request line from an encoded index. It accepts a binary code over a valid/ready handshake and drives the matching one-hot output bit for a fixed number of cycles. It then enforces a programmable quiet gap before it accepts the next code. It sits downstream of the 8-to-3 priority encoder, which produces `y[2:0]`, and converts that index back into a timed one-hot strobe for per-channel logic.

## Interface
Parameters:
- `CODE_W`, default 3: code width. Output width is `2**CODE_W`.
- `HOLD`, default 4: cycles the one-hot output is held. Legal range is 1..255.
- `GAP`, default 1: extra idle cycles after the hold, during which `y`=0 and `in_ready`=0. Legal range is 0..255.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: `code` is valid.
- `in_ready`, output, 1: block can accept a code.
- `code`, input, `CODE_W`: index to decode.
- `y`, output, `2**CODE_W`: registered one-hot output. It is all-zero when not driving.
- `y_valid`, output, 1: high exactly while `y` is non-zero.
- `busy`, output, 1: high in any state other than IDLE.
- `count`, output, 16: accepted-code counter. Present only with `PD_COUNT_EN`.

## Operation
States: IDLE, DRIVE and GAP. There is one down-counter `cnt`, 8 bits wide.

Reset (asynchronous, while `rst_n`=0):
- State goes to IDLE.
- `y`=0, `y_valid`=0, `busy`=0 and `cnt`=0.
- `in_ready`=1 once reset is released.
- `count`=0.

IDLE:
- `in_ready`=1.
- A transfer occurs on a rising edge where `in_valid` and `in_ready` are both 1.
- On a transfer, the block registers `y <= 1 << code` and `y_valid <= 1`, loads `cnt <= HOLD-1`, and moves to DRIVE.

DRIVE:
- `in_ready`=0. `in_valid` and `code` are ignored, and changing `code` has no effect on `y`.
- If `cnt`≠0, the block decrements `cnt`.
- If `cnt`=0, the block clears `y` to 0 and `y_valid` to 0.
  - If `GAP`>0, it loads `cnt <= GAP-1` and moves to GAP.
  - Otherwise it moves to IDLE.

GAP:
- `in_ready`=0 and `y`=0.
- If `cnt`≠0, the block decrements `cnt`. If `cnt`=0, it moves to IDLE.

Outputs:
- `in_ready` is decoded from the registered state only. It never depends combinationally on `in_valid`.
- `busy` = (state ≠ IDLE).
- At most one bit of `y` is ever set. Every code value from 0 to `2**CODE_W-1` is legal, and there is no out-of-range case.

## Timing
- Transfer at edge k: `y` and `y_valid` are visible from edge k to edge k+HOLD, i.e. exactly `HOLD` cycles.
- Edge k+HOLD: `y` returns to 0.
- IDLE is re-entered at edge k+HOLD+GAP.
- The earliest next transfer is at edge k+HOLD+GAP+1. The minimum period is HOLD+GAP+1 cycles, and `y`=0 for at least one cycle between consecutive strobes.
- `in_valid` held high continuously is accepted once per period. The value transferred is `code` sampled at the transfer edge.
- Reset mid-DRIVE or mid-GAP clears `y` immediately, without waiting for a clock edge. The first transfer after reset is possible on the first rising edge with `rst_n`=1.
- `cnt` never wraps. All loads are ≤254 and `cnt` is only decremented when it is non-zero.

## Configuration
- `PD_COUNT_EN` defined: adds the `count` output port. `count` increments by 1 on every transfer and saturates at 16'hFFFF. Asynchronous reset sets it to 0.
- `PD_COUNT_EN` undefined: no `count` port and no counter logic. All other behaviour is identical.

## Test plan
- Reset check: assert `rst_n`=0 → `y`=8'h00, `y_valid`=0, `busy`=0. Release reset → `in_ready`=1.
- Single decode, HOLD=4, GAP=1: transfer `code`=5 at edge k.
  - `y`=8'b0010_0000 for edges k through k+3, with `y_valid`=1.
  - `y`=0 at edge k+4.
  - `in_ready`=1 after edge k+5.
- Sweep: hold `in_valid`=1 and present codes 0..7, advancing each on its transfer → `y` = 01,02,04,…,80 in order, with transfers 6 cycles apart.
- Ignore while busy: during DRIVE, toggle `code` and pulse `in_valid` → `y` unchanged, no extra transfer, and `count` (if enabled) unchanged.
- Reset mid-operation: drop `rst_n` two cycles into DRIVE → `y`=0 without a clock edge. After release, `code`=3 is accepted → `y`=8'h08.
- Boundary, HOLD=1 and GAP=0: continuous `in_valid` → `y` is active 1 cycle, then 0 for 1 cycle, repeating. With `PD_COUNT_EN`, forcing `count` to 16'hFFFE, two transfers → `count` ends at 16'hFFFF and does not wrap.
